// File: rtl/led_bank_scheduler_if.sv
// led_bank_scheduler_if: requester-side bus of the LED bank scheduler.
// Carries the per-source requests and patterns in, and the one-hot grant,
// LED drive and active source index out.
// The master modport is the requester side; the slave modport is the scheduler.
interface led_bank_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int LED_W   = 6
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]       src_req;
    logic [NUM_SRC*LED_W-1:0] src_data;
    logic [NUM_SRC-1:0]       src_gnt;
    logic [LED_W-1:0]         LED;
    logic [SRC_W-1:0]         active_src;

    modport master (
        output src_req,
        output src_data,
        input  src_gnt,
        input  LED,
        input  active_src
    );

    modport slave (
        input  src_req,
        input  src_data,
        output src_gnt,
        output LED,
        output active_src
    );
endinterface

// File: rtl/led_bank_scheduler.sv
// led_bank_scheduler: shares one LED bank among NUM_SRC pattern requesters.
// Debounced SW[1:0] picks the mode: 00 round-robin with a dwell time per slot,
// 01 source 0 only, 10 source 1 only, 11 freeze (LEDs hold, no grant).
// Optional build macro LED_BANK_SCHED_HEARTBEAT_EN: LED[LED_W-1] becomes a
// free-running heartbeat toggling every DWELL_CYC cycles; the remaining LED
// bits carry the grantee data.
module led_bank_scheduler #(
    parameter int NUM_SRC   = 4,
    parameter int LED_W     = 6,
    parameter int DWELL_CYC = 1000000,
    parameter int DB_CYC    = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 SW,
    led_bank_scheduler_if.slave        bus
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int DW_W  = $clog2(DWELL_CYC);
    localparam int DB_W  = $clog2(DB_CYC + 1);

    localparam logic [SRC_W-1:0] RR_INIT    = SRC_W'(NUM_SRC - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYC - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYC - 1);
    localparam logic [NUM_SRC-1:0] SRC0_OH  = {{(NUM_SRC-1){1'b0}}, 1'b1};
    localparam logic [NUM_SRC-1:0] SRC1_OH  = SRC0_OH << 1;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_FIX0   = 2'b01;
    localparam logic [1:0] MODE_FIX1   = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // First requesting source in circular order ptr+1, ptr+2, ..., ptr.
    // Returns ptr when nothing requests; callers gate on |req.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                 input logic [SRC_W-1:0]   ptr);
        logic [SRC_W-1:0] pick;
        int               idx;
        pick = ptr;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx  = (int'(ptr) + k) % NUM_SRC;
            pick = req[idx] ? idx[SRC_W-1:0] : pick;
        end
        return pick;
    endfunction

    // Switch input path
    logic [1:0]            sw_meta_r;
    logic [1:0]            sw_sync_r;
    logic [1:0]            sw_db_r;
    logic [1:0]            sw_db_s;
    logic [1:0][DB_W-1:0]  db_cnt_r;
    logic [1:0][DB_W-1:0]  db_cnt_s;

    // Scheduler state
    state_t                state_r,  state_s;
    logic [NUM_SRC-1:0]    gnt_r,    gnt_s;
    logic [SRC_W-1:0]      idx_r,    idx_s;
    logic [LED_W-1:0]      led_r,    led_s;
    logic [SRC_W-1:0]      rr_ptr_r, rr_ptr_s;
    logic [DW_W-1:0]       dwell_r,  dwell_s;
    logic [1:0]            gmode_r,  gmode_s;

    // Arbitration helpers
    logic [NUM_SRC-1:0]    elig_s;
    logic [SRC_W-1:0]      pick_s;
    logic [NUM_SRC-1:0]    pick_oh_s;
    logic                  grantee_req_s;
    logic [LED_W-1:0]      grantee_data_s;

    // Two-flop synchronizer plus debounced switch state and per-bit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_r <= 2'b00;
            sw_sync_r <= 2'b00;
            sw_db_r   <= 2'b00;
            db_cnt_r  <= {2{{DB_W{1'b0}}}};
        end else begin
            sw_meta_r <= SW;
            sw_sync_r <= sw_meta_r;
            sw_db_r   <= sw_db_s;
            db_cnt_r  <= db_cnt_s;
        end
    end

    // Debounce: accept a bit after DB_CYC consecutive cycles differing from sw_db.
    always_comb begin
        sw_db_s  = sw_db_r;
        db_cnt_s = db_cnt_r;
        for (int i = 0; i < 2; i++) begin
            if (sw_sync_r[i] != sw_db_r[i]) begin
                if (db_cnt_r[i] == DB_LAST) begin
                    sw_db_s[i]  = sw_sync_r[i];
                    db_cnt_s[i] = {DB_W{1'b0}};
                end else begin
                    db_cnt_s[i] = db_cnt_r[i] + DB_W'(1);
                end
            end else begin
                db_cnt_s[i] = {DB_W{1'b0}};
            end
        end
    end

    // Eligible requests for the current mode and the round-robin winner.
    always_comb begin
        case (sw_db_r)
            MODE_AUTO: elig_s = bus.src_req;
            MODE_FIX0: elig_s = bus.src_req & SRC0_OH;
            MODE_FIX1: elig_s = bus.src_req & SRC1_OH;
            default:   elig_s = {NUM_SRC{1'b0}};
        endcase
        pick_s         = rr_pick(elig_s, rr_ptr_r);
        pick_oh_s      = SRC0_OH << pick_s;
        grantee_req_s  = bus.src_req[idx_r];
        grantee_data_s = bus.src_data[idx_r*LED_W +: LED_W];
    end

    // Scheduler state register; all outputs come straight from these flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            gnt_r    <= {NUM_SRC{1'b0}};
            idx_r    <= {SRC_W{1'b0}};
            led_r    <= {LED_W{1'b0}};
            rr_ptr_r <= RR_INIT;
            dwell_r  <= {DW_W{1'b0}};
            gmode_r  <= MODE_AUTO;
        end else begin
            state_r  <= state_s;
            gnt_r    <= gnt_s;
            idx_r    <= idx_s;
            led_r    <= led_s;
            rr_ptr_r <= rr_ptr_s;
            dwell_r  <= dwell_s;
            gmode_r  <= gmode_s;
        end
    end

    // Next-state logic: arbitration, dwell expiry, mode changes and freeze.
    always_comb begin
        state_s  = state_r;
        gnt_s    = gnt_r;
        idx_s    = idx_r;
        led_s    = led_r;
        rr_ptr_s = rr_ptr_r;
        dwell_s  = dwell_r;
        gmode_s  = gmode_r;
        case (state_r)
            ST_IDLE: begin
                gnt_s = {NUM_SRC{1'b0}};
                idx_s = {SRC_W{1'b0}};
                led_s = {LED_W{1'b0}};
                if (sw_db_r == MODE_FREEZE) begin
                    state_s = ST_HOLD;
                end else if (|elig_s) begin
                    state_s  = ST_GRANT;
                    gnt_s    = pick_oh_s;
                    idx_s    = pick_s;
                    dwell_s  = DWELL_LAST;
                    gmode_s  = sw_db_r;
                    rr_ptr_s = (sw_db_r == MODE_AUTO) ? pick_s : rr_ptr_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // LED follows the live data of the registered grantee.
                led_s = grantee_data_s;
                if (sw_db_r != gmode_r) begin
                    // A mode change beats expiry; arbitration restarts from IDLE.
                    gnt_s = {NUM_SRC{1'b0}};
                    idx_s = {SRC_W{1'b0}};
                    if (sw_db_r == MODE_FREEZE) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_IDLE;
                        led_s   = {LED_W{1'b0}};
                    end
                end else if (gmode_r == MODE_AUTO) begin
                    if (!grantee_req_s || (dwell_r == {DW_W{1'b0}})) begin
                        // Slot over: switch straight to the next requester, or
                        // keep the grant when only the grantee still requests.
                        if (|elig_s) begin
                            state_s  = ST_GRANT;
                            gnt_s    = pick_oh_s;
                            idx_s    = pick_s;
                            dwell_s  = DWELL_LAST;
                            rr_ptr_s = pick_s;
                        end else begin
                            state_s = ST_IDLE;
                            gnt_s   = {NUM_SRC{1'b0}};
                            idx_s   = {SRC_W{1'b0}};
                            led_s   = {LED_W{1'b0}};
                        end
                    end else begin
                        dwell_s = dwell_r - DW_W'(1);
                    end
                end else begin
                    // Fixed-source modes ignore dwell and end only on request drop.
                    if (!grantee_req_s) begin
                        state_s = ST_IDLE;
                        gnt_s   = {NUM_SRC{1'b0}};
                        idx_s   = {SRC_W{1'b0}};
                        led_s   = {LED_W{1'b0}};
                    end else begin
                        state_s = ST_GRANT;
                    end
                end
            end
            ST_HOLD: begin
                gnt_s = {NUM_SRC{1'b0}};
                idx_s = {SRC_W{1'b0}};
                if (sw_db_r != MODE_FREEZE) begin
                    state_s = ST_IDLE;
                    led_s   = {LED_W{1'b0}};
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = {NUM_SRC{1'b0}};
                idx_s   = {SRC_W{1'b0}};
                led_s   = {LED_W{1'b0}};
            end
        endcase
    end

    assign bus.src_gnt    = gnt_r;
    assign bus.active_src = idx_r;

`ifdef LED_BANK_SCHED_HEARTBEAT_EN
    logic [DW_W-1:0] hb_cnt_r;
    logic            hb_r;

    // Free-running heartbeat, independent of scheduler state and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_r <= {DW_W{1'b0}};
            hb_r     <= 1'b0;
        end else if (hb_cnt_r == DWELL_LAST) begin
            hb_cnt_r <= {DW_W{1'b0}};
            hb_r     <= ~hb_r;
        end else begin
            hb_cnt_r <= hb_cnt_r + DW_W'(1);
            hb_r     <= hb_r;
        end
    end

    assign bus.LED = {hb_r, led_r[LED_W-2:0]};
`else
    assign bus.LED = led_r;
`endif

endmodule

// File: tb/tb_led_bank_scheduler.sv
// tb_led_bank_scheduler: directed bench for led_bank_scheduler with
// NUM_SRC=4, LED_W=6, DWELL_CYC=4, DB_CYC=3. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, so each step reflects the
// register state after that edge. Edge numbers in comments count from reset release.
module tb_led_bank_scheduler;
    localparam int NUM_SRC   = 4;
    localparam int LED_W     = 6;
    localparam int DWELL_CYC = 4;
    localparam int DB_CYC    = 3;

    logic       clk;
    logic       rst;
    logic [1:0] sw;
    int         total;
    int         bad;
    logic [3:0] exp_gnt;
    logic [5:0] exp_led;

    led_bank_scheduler_if #(.NUM_SRC(NUM_SRC), .LED_W(LED_W)) bus ();

    led_bank_scheduler #(
        .NUM_SRC  (NUM_SRC),
        .LED_W    (LED_W),
        .DWELL_CYC(DWELL_CYC),
        .DB_CYC   (DB_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SW (sw),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total = total + 1;
        assert (obs === expv) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_gnt(input string tag, input logic [3:0] expv);
        check(tag, 32'(bus.src_gnt), 32'(expv));
    endtask

    task automatic check_led(input string tag, input logic [5:0] expv);
        check(tag, 32'(bus.LED), 32'(expv));
    endtask

    task automatic check_act(input string tag, input logic [1:0] expv);
        check(tag, 32'(bus.active_src), 32'(expv));
    endtask

    initial begin
        clk          = 1'b0;
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        sw           = 2'b00;
        bus.src_req  = 4'b0000;
        bus.src_data = {6'h33, 6'h2A, 6'h22, 6'h11};
        tick(2);
        check_gnt("reset_gnt", 4'b0000);
        check_led("reset_led", 6'h00);
        check_act("reset_act", 2'd0);

        // 1: round robin between sources 0 and 2, four cycles each (E1..E12)
        rst         = 1'b0;
        bus.src_req = 4'b0101;
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            exp_gnt = ((((c - 1) / 4) % 2) == 0) ? 4'b0001 : 4'b0100;
            exp_led = (c == 1) ? 6'h00 : (((((c - 2) / 4) % 2) == 0) ? 6'h11 : 6'h2A);
            check_gnt("rr_gnt", exp_gnt);
            check_led("rr_led", exp_led);
        end

        // 2: only source 2 requests; grant survives dwell reloads (E13..E24)
        bus.src_req = 4'b0100;
        for (int c = 13; c <= 24; c++) begin
            tick(1);
            check_gnt("solo_gnt", 4'b0100);
            check_act("solo_act", 2'd2);
            check_led("solo_led", (c == 13) ? 6'h11 : 6'h2A);
        end

        // 3a: two-cycle SW glitch must not change the mode (E25..E32)
        sw = 2'b01;
        for (int c = 0; c < 2; c++) begin
            tick(1);
            check_gnt("glitch_gnt", 4'b0100);
        end
        sw = 2'b00;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            check_gnt("glitch_after_gnt", 4'b0100);
        end

        // 3b: SW held at 01; debounced at E37, grant drops at E38
        sw = 2'b01;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check_gnt("fix0_wait_gnt", 4'b0100);
        end
        bus.src_req = 4'b0101;
        tick(1);
        check_gnt("fix0_gap_gnt", 4'b0000);
        check_led("fix0_gap_led", 6'h00);
        check_act("fix0_gap_act", 2'd0);
        tick(1);
        check_gnt("fix0_gnt", 4'b0001);
        check_act("fix0_act", 2'd0);
        check_led("fix0_led0", 6'h00);
        tick(1);
        check_led("fix0_led", 6'h11);
        for (int c = 0; c < 4; c++) begin
            tick(1);
            check_gnt("fix0_nodwell_gnt", 4'b0001);
        end
        bus.src_req = 4'b0100;
        tick(1);
        check_gnt("fix0_drop_gnt", 4'b0000);
        check_led("fix0_drop_led", 6'h00);
        tick(1);
        check_gnt("fix0_idle_gnt", 4'b0000);

        // 4: AUTO grant to source 1 showing 6'h15, then FREEZE
        sw                   = 2'b00;
        bus.src_req          = 4'b0010;
        bus.src_data[6 +: 6] = 6'h15;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check_gnt("auto_wait_gnt", 4'b0000);
        end
        tick(1);
        check_gnt("pre_freeze_gnt", 4'b0010);
        check_act("pre_freeze_act", 2'd1);
        tick(1);
        check_led("pre_freeze_led", 6'h15);
        sw = 2'b11;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check_gnt("freeze_wait_gnt", 4'b0010);
        end
        tick(1);
        check_gnt("hold_gnt", 4'b0000);
        check_act("hold_act", 2'd0);
        check_led("hold_led", 6'h15);
        bus.src_data[6 +: 6] = 6'h3F;
        bus.src_req          = 4'b1101;
        for (int c = 0; c < 2; c++) begin
            tick(1);
            check_gnt("hold_req_gnt", 4'b0000);
            check_led("hold_req_led", 6'h15);
        end
        sw = 2'b00;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check_gnt("unfreeze_wait_gnt", 4'b0000);
            check_led("unfreeze_wait_led", 6'h15);
        end
        tick(1);
        check_gnt("unfreeze_idle_gnt", 4'b0000);
        check_led("unfreeze_idle_led", 6'h00);
        tick(1);
        check_gnt("resume_gnt", 4'b0100);
        check_act("resume_act", 2'd2);

        // 5: grantee 1 drops its request at dwell count 2 while source 3 waits
        bus.src_req = 4'b0110;
        tick(1);
        check_led("resume_led", 6'h2A);
        tick(3);
        check_gnt("g1_gnt", 4'b0010);
        check_act("g1_act", 2'd1);
        tick(1);
        check_gnt("g1_dwell2_gnt", 4'b0010);
        check_led("g1_led", 6'h3F);
        bus.src_req = 4'b1000;
        tick(1);
        check_gnt("drop_switch_gnt", 4'b1000);
        check_act("drop_switch_act", 2'd3);
        tick(1);
        check_led("drop_switch_led", 6'h33);

        // 6: one-cycle reset mid-grant, then the first grant goes to source 0
        rst = 1'b1;
        tick(1);
        check_gnt("midrst_gnt", 4'b0000);
        check_led("midrst_led", 6'h00);
        check_act("midrst_act", 2'd0);
        rst         = 1'b0;
        bus.src_req = 4'b1111;
        tick(1);
        check_gnt("postrst_gnt", 4'b0001);
        check_act("postrst_act", 2'd0);
        tick(1);
        check_led("postrst_led", 6'h11);

        // FIX1: mode change from AUTO drops the grant, then source 1 is held
        sw = 2'b10;
        tick(3);
        check_gnt("auto_next_gnt", 4'b0010);
        check_act("auto_next_act", 2'd1);
        tick(3);
        check_gnt("fix1_gap_gnt", 4'b0000);
        check_led("fix1_gap_led", 6'h00);
        tick(1);
        check_gnt("fix1_gnt", 4'b0010);
        check_act("fix1_act", 2'd1);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check_gnt("fix1_hold_gnt", 4'b0010);
        end
        check_led("fix1_led", 6'h3F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
